// File: rtl/axi_read_mem_if.sv
// AR/R channel bundle for the byte-addressed AXI3 read memory slave.
interface axi_read_mem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 2
);
   logic [ID_W-1:0]   ARID;
   logic [ADDR_W-1:0] ARADDR;
   logic [3:0]        ARLEN;
   logic [2:0]        ARSIZE;
   logic [1:0]        ARBURST;
   logic              ARVALID;
   logic              ARREADY;
   logic [ID_W-1:0]   RID;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              RVALID;
   logic              RREADY;

   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );
endinterface

// File: rtl/axi_read_mem.sv
// Byte-addressed AXI3 read slave: one burst at a time, FIXED/INCR/WRAP,
// narrow/unaligned beats, per-beat SLVERR/DECERR, plus a byte-strobed preload port.
module axi_read_mem #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int ID_W         = 2,
   parameter int DEPTH        = 128,
   parameter int INIT_PATTERN = 1
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   axi_read_mem_if.slave       axi,
   input  logic                mem_we,
   input  logic [ADDR_W-1:0]   mem_waddr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W/8-1:0] mem_wstrb
);
   localparam int BYTES  = DATA_W / 8;
   localparam int LANE_W = $clog2(BYTES);
   localparam int WORDS  = DEPTH / BYTES;
   localparam int WIDX_W = $clog2(WORDS);

   typedef enum logic {IDLE, DATA} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        len_q, len_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [2:0]        size_q, size_d;
   logic [1:0]        burst_q, burst_d;
   logic              slverr_q, slverr_d;
   logic              ovf_q, ovf_d;
   logic              rvalid_q, rvalid_d;
   logic              rlast_q, rlast_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [ID_W-1:0]   rid_q, rid_d;

   // Burst-level protocol errors are decided once, at the AR handshake.
   logic [ADDR_W-1:0] ar_nmask;
   logic              ar_slverr;
   assign ar_nmask  = (ADDR_W'(1) << axi.ARSIZE) - ADDR_W'(1);
   assign ar_slverr = (axi.ARSIZE > 3'(LANE_W)) || (axi.ARBURST == 2'b11) ||
                      ((axi.ARBURST == 2'b10) &&
                       (!(axi.ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15}) ||
                        ((axi.ARADDR & ar_nmask) != '0)));

   logic [ADDR_W-1:0] n_bytes, q_aligned, wrap_mask, nxt_addr;
   logic [ADDR_W:0]   incr_sum;
   logic              nxt_ovf;
   assign n_bytes   = ADDR_W'(1) << size_q;
   assign q_aligned = addr_q & ~(n_bytes - ADDR_W'(1));
   assign incr_sum  = {1'b0, q_aligned} + {1'b0, n_bytes};
   assign wrap_mask = (ADDR_W'({1'b0, len_q} + 5'd1) << size_q) - ADDR_W'(1);

   always_comb begin
      nxt_addr = addr_q;
      nxt_ovf  = ovf_q;
      case (burst_q)
         2'b01: begin
            nxt_addr = incr_sum[ADDR_W-1:0];
            // Running off the top of the address space is sticky, never wraps to 0.
            nxt_ovf  = ovf_q || incr_sum[ADDR_W];
         end
         2'b10:   nxt_addr = (addr_q & ~wrap_mask) | ((addr_q + n_bytes) & wrap_mask);
         default: nxt_addr = addr_q;
      endcase
   end

   // One beat datapath, fed by the AR channel in IDLE and by the next address in DATA.
   logic [ADDR_W-1:0] b_addr, b_nmask, b_aligned;
   logic [2:0]        b_size;
   logic              b_slverr, b_ovf, b_decerr;
   logic [LANE_W:0]   b_lo, b_hi;
   logic [WIDX_W-1:0] b_widx;
   logic [DATA_W-1:0] b_data;
   logic [1:0]        b_resp;

   assign b_addr    = (state_q == IDLE) ? axi.ARADDR : nxt_addr;
   assign b_size    = (state_q == IDLE) ? axi.ARSIZE : size_q;
   assign b_slverr  = (state_q == IDLE) ? ar_slverr  : slverr_q;
   assign b_ovf     = (state_q == IDLE) ? 1'b0       : nxt_ovf;
   assign b_nmask   = (ADDR_W'(1) << b_size) - ADDR_W'(1);
   assign b_aligned = b_addr & ~b_nmask;
   assign b_decerr  = b_ovf || (b_aligned >= ADDR_W'(DEPTH));
   assign b_lo      = {1'b0, b_addr[LANE_W-1:0]};
   assign b_hi      = {1'b0, b_aligned[LANE_W-1:0]} + b_nmask[LANE_W:0];
   assign b_widx    = b_addr[LANE_W +: WIDX_W];
   assign b_resp    = b_slverr ? 2'b10 : (b_decerr ? 2'b11 : 2'b00);

   logic              wr_en;
   logic [WIDX_W-1:0] wr_widx;
   assign wr_en   = mem_we && (mem_waddr < ADDR_W'(DEPTH));
   assign wr_widx = mem_waddr[LANE_W +: WIDX_W];

   // Each lane stores data XOR its init byte, so power-up-zero RAM reads back as the pattern.
   for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] pat_wr, pat_rd, rd_byte;
      logic       lane_on;

      assign pat_wr  = (INIT_PATTERN != 0) ? 8'({wr_widx, LANE_W'(gi)}) : 8'h00;
      assign pat_rd  = (INIT_PATTERN != 0) ? 8'({b_widx, LANE_W'(gi)}) : 8'h00;
      assign rd_byte = lane_mem[b_widx] ^ pat_rd;
      assign lane_on = ((LANE_W+1)'(gi) >= b_lo) && ((LANE_W+1)'(gi) <= b_hi);
      assign b_data[gi*8 +: 8] = (lane_on && !b_slverr && !b_decerr) ? rd_byte : 8'h00;

      always_ff @(posedge ACLK) begin
         if (wr_en && mem_wstrb[gi]) begin
            lane_mem[wr_widx] <= mem_wdata[gi*8 +: 8] ^ pat_wr;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      addr_d   = addr_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      size_d   = size_q;
      burst_d  = burst_q;
      slverr_d = slverr_q;
      ovf_d    = ovf_q;
      rvalid_d = rvalid_q;
      rlast_d  = rlast_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rid_d    = rid_q;
      case (state_q)
         IDLE: begin
            if (axi.ARVALID) begin
               state_d  = DATA;
               id_d     = axi.ARID;
               addr_d   = axi.ARADDR;
               len_d    = axi.ARLEN;
               size_d   = axi.ARSIZE;
               burst_d  = axi.ARBURST;
               slverr_d = ar_slverr;
               ovf_d    = 1'b0;
               cnt_d    = 4'd0;
               rvalid_d = 1'b1;
               rlast_d  = (axi.ARLEN == 4'd0);
               rid_d    = axi.ARID;
               rdata_d  = b_data;
               rresp_d  = b_resp;
            end
         end
         DATA: begin
            // RVALID is always high here, so RREADY alone completes the beat.
            if (axi.RREADY) begin
               if (cnt_q == len_q) begin
                  state_d  = IDLE;
                  rvalid_d = 1'b0;
                  rlast_d  = 1'b0;
               end else begin
                  addr_d  = nxt_addr;
                  ovf_d   = nxt_ovf;
                  cnt_d   = cnt_q + 4'd1;
                  rlast_d = ((cnt_q + 4'd1) == len_q);
                  rdata_d = b_data;
                  rresp_d = b_resp;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q  <= IDLE;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         slverr_q <= 1'b0;
         ovf_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= '0;
         rid_q    <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         size_q   <= size_d;
         burst_q  <= burst_d;
         slverr_q <= slverr_d;
         ovf_q    <= ovf_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
         rid_q    <= rid_d;
      end
   end

   assign axi.ARREADY = (state_q == IDLE);
   assign axi.RVALID  = rvalid_q;
   assign axi.RLAST   = rlast_q;
   assign axi.RDATA   = rdata_q;
   assign axi.RRESP   = rresp_q;
   assign axi.RID     = rid_q;
endmodule

// File: tb/tb_axi_read_mem.sv
// Scoreboard bench for axi_read_mem: directed test-plan bursts, then randomized
// bursts checked against a byte-array reference model.
module tb_axi_read_mem;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int ID_W   = 2;
   localparam int DEPTH  = 128;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [31:0]     data;
      logic [1:0]      resp;
      logic            last;
   } beat_t;

   logic              ACLK    = 1'b0;
   logic              ARESETn = 1'b1;
   logic              mem_we  = 1'b0;
   logic [ADDR_W-1:0] mem_waddr = '0;
   logic [DATA_W-1:0] mem_wdata = '0;
   logic [3:0]        mem_wstrb = '0;

   axi_read_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) axi ();

   axi_read_mem #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .INIT_PATTERN(1)
   ) dut (
      .ACLK(ACLK),
      .ARESETn(ARESETn),
      .axi(axi),
      .mem_we(mem_we),
      .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb)
   );

   always #5 ACLK = ~ACLK;

   beat_t      sb[$];
   logic       rr_bits[$];
   logic       rr_rand = 1'b0;
   logic       busy = 1'b0;
   int         hs_count = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] model_mem [DEPTH];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic exp_beat(input int id, input logic [31:0] data, input logic [1:0] resp,
                           input logic last);
      beat_t e;
      e.id = ID_W'(id); e.data = data; e.resp = resp; e.last = last;
      sb.push_back(e);
   endtask

   // Reference model: beat addresses and lanes straight from the burst rules.
   task automatic push_model(input int id, input int addr, input int len, input int size,
                             input int burst);
      int n, st_al, bound, base, a, al;
      logic [31:0] d;
      logic [1:0]  r;
      bit slv;
      n     = 1 << size;
      slv   = (n > DATA_W/8) || (burst == 3) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
              (burst == 2 && (addr % n) != 0);
      st_al = addr - addr % n;
      bound = (len + 1) * n;
      base  = addr - addr % bound;
      for (int k = 0; k <= len; k++) begin
         case (burst)
            0:       a = addr;
            1:       a = (k == 0) ? addr : st_al + k * n;
            default: a = base + (addr - base + k * n) % bound;
         endcase
         al = a - a % n;
         d  = '0;
         if (slv) r = 2'b10;
         else if (al >= DEPTH) r = 2'b11;
         else begin
            r = 2'b00;
            for (int b = a; b < al + n; b++) d[(b % 4) * 8 +: 8] = model_mem[b];
         end
         exp_beat(id, d, r, k == len);
      end
   endtask

   task automatic issue(input int id, input int addr, input int len, input int size,
                        input int burst);
      $display("AR id=%0d addr=%h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
      axi.ARID    = ID_W'(id);
      axi.ARADDR  = ADDR_W'(addr);
      axi.ARLEN   = 4'(len);
      axi.ARSIZE  = 3'(size);
      axi.ARBURST = 2'(burst);
      axi.ARVALID = 1'b1;
      @(posedge ACLK); #1;
      axi.ARVALID = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while ((sb.size() != 0 || busy) && c < budget) begin
         @(posedge ACLK); #1;
         c++;
      end
      if (sb.size() != 0 || busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_timeout: got %0d beats outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic preload(input int addr, input logic [31:0] data, input logic [3:0] strb);
      $display("PRELOAD addr=%h data=%h strb=%b", addr, data, strb);
      mem_we    = 1'b1;
      mem_waddr = ADDR_W'(addr);
      mem_wdata = data;
      mem_wstrb = strb;
      for (int l = 0; l < 4; l++) if (strb[l]) model_mem[(addr & ~3) + l] = data[l*8 +: 8];
      @(posedge ACLK); #1;
      mem_we = 1'b0;
   endtask

   initial begin : rready_drv
      axi.RREADY = 1'b1;
      forever begin
         @(posedge ACLK); #2;
         if (rr_bits.size() != 0) axi.RREADY = rr_bits.pop_front();
         else if (rr_rand) axi.RREADY = ($urandom_range(0, 3) != 0);
         else axi.RREADY = 1'b1;
      end
   end

   // Monitor: protocol checks every cycle, scoreboard pop on each R handshake.
   initial begin : monitor
      logic            stall_prev;
      logic [63:0]     held;
      beat_t           e;
      stall_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge ACLK);
         if (!ARESETn) begin
            sb.delete();
            busy = 1'b0;
            stall_prev = 1'b0;
         end else begin
            chk("arready", 64'(axi.ARREADY), 64'(!busy));
            chk("rvalid", 64'(axi.RVALID), 64'(busy));
            if (stall_prev)
               chk("stall_hold", 64'({axi.RID, axi.RDATA, axi.RRESP, axi.RLAST}), held);
            if (axi.RVALID && axi.RREADY) begin
               $display("R id=%0d data=%h resp=%0d last=%0d", axi.RID, axi.RDATA,
                        axi.RRESP, axi.RLAST);
               if (sb.size() == 0) begin
                  chk("unexpected_beat", 64'(1), 64'(0));
               end else begin
                  e = sb.pop_front();
                  chk("beat_id", 64'(axi.RID), 64'(e.id));
                  chk("beat_data", 64'(axi.RDATA), 64'(e.data));
                  chk("beat_resp_last", 64'({axi.RRESP, axi.RLAST}), 64'({e.resp, e.last}));
               end
               hs_count++;
               if (axi.RLAST) busy = 1'b0;
            end
            stall_prev = axi.RVALID && !axi.RREADY;
            held = 64'({axi.RID, axi.RDATA, axi.RRESP, axi.RLAST});
            if (axi.ARVALID && axi.ARREADY) busy = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int start, c, id, addr, len, size, burst, r;
      axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0;
      axi.ARBURST = '0; axi.ARVALID = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'(i);

      #1 ARESETn = 1'b0;
      #3;
      chk("rst_arready", 64'(axi.ARREADY), 64'(1));
      chk("rst_rvalid", 64'(axi.RVALID), 64'(0));
      chk("rst_rlast", 64'(axi.RLAST), 64'(0));
      chk("rst_rdata", 64'(axi.RDATA), 64'(0));
      chk("rst_rresp_rid", 64'({axi.RRESP, axi.RID}), 64'(0));
      repeat (3) @(posedge ACLK);
      #3 ARESETn = 1'b1;
      @(posedge ACLK); #1;

      // INCR aligned words, ID echo
      exp_beat(1, 32'h03020100, 2'b00, 1'b0);
      exp_beat(1, 32'h07060504, 2'b00, 1'b0);
      exp_beat(1, 32'h0B0A0908, 2'b00, 1'b0);
      exp_beat(1, 32'h0F0E0D0C, 2'b00, 1'b1);
      issue(1, 'h00, 3, 2, 1); wait_idle(100);
      // narrow and unaligned INCR
      exp_beat(0, 32'h00000100, 2'b00, 1'b0);
      exp_beat(0, 32'h00020000, 2'b00, 1'b0);
      exp_beat(0, 32'h03000000, 2'b00, 1'b1);
      issue(0, 'h01, 2, 0, 1); wait_idle(100);
      exp_beat(2, 32'h03020000, 2'b00, 1'b0);
      exp_beat(2, 32'h07060504, 2'b00, 1'b1);
      issue(2, 'h02, 1, 2, 1); wait_idle(100);
      // WRAP good and illegal lengths / alignment / reserved burst
      exp_beat(3, 32'h0B0A0908, 2'b00, 1'b0);
      exp_beat(3, 32'h0F0E0D0C, 2'b00, 1'b0);
      exp_beat(3, 32'h03020100, 2'b00, 1'b0);
      exp_beat(3, 32'h07060504, 2'b00, 1'b1);
      issue(3, 'h08, 3, 2, 2); wait_idle(100);
      for (int k = 0; k < 3; k++) exp_beat(1, 32'h0, 2'b10, k == 2);
      issue(1, 'h08, 2, 2, 2); wait_idle(100);
      for (int k = 0; k < 2; k++) exp_beat(0, 32'h0, 2'b10, k == 1);
      issue(0, 'h0A, 1, 2, 2); wait_idle(100);
      exp_beat(2, 32'h0, 2'b10, 1'b1);
      issue(2, 'h04, 0, 2, 3); wait_idle(100);
      // FIXED with scripted back-pressure: 3 stall cycles on beat0, 1 on beat1
      rr_bits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 3; k++) exp_beat(1, 32'h13121110, 2'b00, k == 2);
      issue(1, 'h10, 2, 2, 0); wait_idle(100);
      // DECERR at the top of memory, oversize beat
      exp_beat(0, 32'h7F7E7D7C, 2'b00, 1'b0);
      exp_beat(0, 32'h0, 2'b11, 1'b1);
      issue(0, 'h7C, 1, 2, 1); wait_idle(100);
      for (int k = 0; k < 2; k++) exp_beat(3, 32'h0, 2'b10, k == 1);
      issue(3, 'h00, 1, 3, 1); wait_idle(100);
      // preload with partial strobes
      preload('h20, 32'hDEADBEEF, 4'b0101);
      exp_beat(3, 32'h23AD21EF, 2'b00, 1'b1);
      issue(3, 'h20, 0, 2, 1); wait_idle(100);

      // reset while beat1 of a 4-beat burst is on the bus
      exp_beat(2, 32'h43424140, 2'b00, 1'b0);
      start = hs_count;
      issue(2, 'h40, 3, 2, 1);
      c = 0;
      while (hs_count == start && c < 20) begin @(posedge ACLK); #1; c++; end
      chk("reset_test_beat0_seen", 64'(hs_count - start), 64'(1));
      #2 ARESETn = 1'b0;
      #1;
      chk("midrst_rvalid", 64'(axi.RVALID), 64'(0));
      chk("midrst_arready", 64'(axi.ARREADY), 64'(1));
      chk("midrst_rdata_rlast", 64'({axi.RDATA, axi.RLAST}), 64'(0));
      @(negedge ACLK); @(negedge ACLK);
      @(posedge ACLK); #3 ARESETn = 1'b1;
      @(posedge ACLK); #1;
      exp_beat(1, 32'h23AD21EF, 2'b00, 1'b0);
      exp_beat(1, 32'h27262524, 2'b00, 1'b1);
      issue(1, 'h20, 1, 2, 1); wait_idle(100);

      // randomized bursts against the reference model
      rr_rand = 1'b1;
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 3) == 0)
            preload(int'($urandom_range(0, DEPTH - 1)), $urandom, 4'($urandom_range(0, 15)));
         id    = int'($urandom_range(0, 3));
         r     = int'($urandom_range(0, 9));
         burst = (r < 3) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
         size  = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
         len   = int'($urandom_range(0, 15));
         addr  = int'($urandom_range(0, 159));
         if (burst == 2 && $urandom_range(0, 3) != 0) begin
            r    = int'($urandom_range(0, 3));
            len  = (2 << r) - 1;
            addr = addr & ~((1 << size) - 1);
         end
         push_model(id, addr, len, size, burst);
         issue(id, addr, len, size, burst);
         wait_idle(200);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/axi_read_mem.md
Name: axi_read_mem

Overview:
Parametrised, byte-addressed AXI3 read-channel memory slave. It accepts one AR burst at a time, supports FIXED/INCR/WRAP, narrow and unaligned transfers, and returns R beats with byte-lane placement and per-beat error responses. It replaces the fixed 32-bit, 128-byte memory model behind the read slave. It also serves as a standalone read target for ReadMaster benches.

Parameters:
DATA_W, 32, R data width in bits; one of 32 or 64.
ADDR_W, 32, ARADDR width.
ID_W, 2, ARID/RID width.
DEPTH, 128, memory size in bytes; power of 2, multiple of DATA_W/8.
INIT_PATTERN, 1, 1: byte i initialised to i[7:0]; 0: all bytes zero.

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  reset, asynchronous, active-low
ARID  in  ID_W  burst ID
ARADDR  in  ADDR_W  start byte address
ARLEN  in  4  beats-1
ARSIZE  in  3  bytes per beat = 2^ARSIZE
ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
ARVALID  in  1  address valid
ARREADY  out  1  address ready
RID  out  ID_W  echoed ARID
RDATA  out  DATA_W  read data
RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
RLAST  out  1  final beat
RVALID  out  1  data valid
RREADY  in  1  data ready
mem_we  in  1  preload write enable
mem_waddr  in  ADDR_W  preload word address (byte address, low bits ignored)
mem_wdata  in  DATA_W  preload data
mem_wstrb  in  DATA_W/8  preload byte strobes

Behaviour:
- Reset (async assert): state IDLE, ARREADY=1, RVALID=0, RLAST=0, RDATA=0, RRESP=0, RID=0, beat counter=0. Memory contents are not cleared. Reset mid-burst abandons the burst; no further beats are issued.
- States:
  - IDLE: ARREADY=1. On ARVALID&ARREADY, latch ID, address, len, size, burst and go to DATA.
  - DATA: ARREADY=0. The first beat has RVALID=1 on the cycle after the AR handshake (latency 1).
- Beat transfer: a beat completes on RVALID&RREADY. While RVALID&!RREADY, RDATA/RRESP/RLAST/RID are held stable.
- After a non-last handshake, the next beat is presented on the following cycle. RVALID stays high, giving 1 beat/cycle throughput.
- RLAST=1 only on beat ARLEN. Its handshake returns the block to IDLE: RVALID=0 and ARREADY=1 on the next cycle.
- Address sequence (N=2^size):
  - FIXED: every beat uses the start address.
  - INCR: beat0 = start; subsequent beats = (start aligned down to N) + k*N.
  - WRAP: boundary = (len+1)*N. Address = aligned start + k*N, wrapped modulo boundary within the boundary-aligned block.
- Lane placement: for beat address A, bytes A..(aligned(A)+N-1) go to lanes A mod (DATA_W/8). All other lanes read 0. An unaligned first beat therefore zeroes lanes below the start offset.
- Error cases:
  - SLVERR for every beat, with RDATA=0, when any of these holds: ARSIZE > log2(DATA_W/8); ARBURST=11; WRAP with ARLEN not in {1,3,7,15}; WRAP with unaligned start.
  - DECERR with RDATA=0 for any beat whose aligned address >= DEPTH. Evaluated per beat; earlier in-range beats stay OKAY.
  - Error bursts still deliver exactly ARLEN+1 beats with correct RLAST.
- Preload port: write on the rising edge when mem_we=1, per set strobe. A same-cycle read of the same byte returns the old value.
- Width rules: address arithmetic is ADDR_W bits, with no wrap past 2^ADDR_W. The beat counter is 4 bits.

Test Plan:
1. DATA_W=32, INCR len3 size2 addr 0x00 ID=1 -> RDATA 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; RLAST on beat 3 only; RRESP=00; RID=1; first RVALID 1 cycle after AR handshake.
2. INCR len2 size0 addr 0x01 -> 0x00000100, 0x00020000, 0x03000000. INCR len1 size2 addr 0x02 -> 0x03020000, 0x07060504.
3. WRAP len3 size2 addr 0x08 -> 0x0B0A0908, 0x0F0E0D0C, 0x03020100, 0x07060504. WRAP len2 -> 3 beats SLVERR, RDATA 0.
4. FIXED len2 size2 addr 0x10, RREADY low 3 cycles on beat0 and 1 cycle on beat1 -> every beat 0x13121110; outputs stable while stalled; ARREADY=0 until the cycle after the RLAST handshake.
5. DEPTH=128, INCR len1 size2 addr 0x7C -> beat0 0x7F7E7D7C OKAY, beat1 RDATA 0 DECERR. ARSIZE=3 with DATA_W=32 -> SLVERR all beats.
6. Preload 0xDEADBEEF with wstrb 4'b0101 at 0x20, then read addr 0x20 -> 0x23AD21EF. Assert ARESETn low during beat1 of a len3 burst -> RVALID=0 immediately; after release ARREADY=1 and a new burst reads correctly.
